// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: single-line fetch buffer answering core fetches and refilling misses from memory
module icache_fetch_responder #(
    parameter int               ADDR_W   = 40,
    parameter int               LINE_W   = 128,
    parameter logic [ADDR_W-1:0] MEM_BASE = 40'h0_8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 40'h0_1000_0000,
    parameter int               CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rsn,
    input  logic              req_valid,
    input  logic              req_kill,
    input  logic [ADDR_W-1:0] req_vaddr,
    input  logic              iflush,
    output logic              resp_ready,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_vaddr,
    output logic              resp_xcpt,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam logic [ADDR_W:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, DRAIN} state_t;

    state_t                  state;
    logic                    buf_valid;
    logic                    nofill;
    logic [ADDR_W-OFF-1:0]   buf_tag;
    logic [LINE_W-1:0]       buf_data;
    logic [ADDR_W-1:0]       lat_vaddr;
    logic [ADDR_W-OFF-1:0]   tag;
    logic                    accept;
    logic                    in_range;
    logic                    hit;
    logic                    fill;

    always_comb begin
        tag      = req_vaddr[ADDR_W-1:OFF];
        accept   = req_valid && resp_ready && !req_kill;
        in_range = (req_vaddr >= MEM_BASE) && ({1'b0, req_vaddr} < MEM_END);
        hit      = buf_valid && !iflush && (buf_tag == tag);
        // a flush seen at any point of the refill, or on the data beat itself, leaves the buffer invalid
        fill     = mem_rsp_valid && (state == MISS_WAIT || state == DRAIN) && !nofill && !iflush;
    end

    always_ff @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            state         <= IDLE;
            resp_ready    <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_vaddr    <= '0;
            resp_xcpt     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            buf_valid     <= 1'b0;
            buf_tag       <= '0;
            buf_data      <= '0;
            lat_vaddr     <= '0;
            nofill        <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (iflush) buf_valid <= 1'b0;
            if (fill) begin
                buf_valid <= 1'b1;
                buf_tag   <= lat_vaddr[ADDR_W-1:OFF];
                buf_data  <= mem_rsp_data;
            end
            case (state)
                IDLE: if (accept) begin
                    resp_vaddr <= req_vaddr;
                    if (!in_range) begin
                        resp_valid <= 1'b1;
                        resp_xcpt  <= 1'b1;
                        resp_data  <= '0;
                    end else if (hit) begin
                        resp_valid <= 1'b1;
                        resp_xcpt  <= 1'b0;
                        resp_data  <= buf_data;
                        hit_cnt    <= hit_cnt + {{(CNT_W-1){1'b0}}, ~&hit_cnt};
                    end else begin
                        lat_vaddr     <= req_vaddr;
                        mem_req_addr  <= {tag, {OFF{1'b0}}};
                        mem_req_valid <= 1'b1;
                        miss_cnt      <= miss_cnt + {{(CNT_W-1){1'b0}}, ~&miss_cnt};
                        nofill        <= 1'b0;
                        resp_ready    <= 1'b0;
                        state         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    nofill <= nofill | iflush;
                    if (req_kill || mem_req_ready) mem_req_valid <= 1'b0;
                    if (req_kill && !mem_req_ready) begin
                        state      <= IDLE;
                        resp_ready <= 1'b1;
                    end else if (mem_req_ready) state <= req_kill ? DRAIN : MISS_WAIT;
                end
                MISS_WAIT: begin
                    nofill <= nofill | iflush;
                    if (mem_rsp_valid) begin
                        state      <= IDLE;
                        resp_ready <= 1'b1;
                        resp_valid <= !req_kill;
                        resp_xcpt  <= 1'b0;
                        resp_data  <= mem_rsp_data;
                        resp_vaddr <= lat_vaddr;
                    end else if (req_kill) state <= DRAIN;
                end
                DRAIN: begin
                    nofill <= nofill | iflush;
                    if (mem_rsp_valid) begin
                        state      <= IDLE;
                        resp_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb_icache_fetch_responder: directed vectors with hand-computed expectations for the fetch responder
module tb_icache_fetch_responder;
    logic         clk = 1'b0;
    logic         rsn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_kill = 1'b0;
    logic [39:0]  req_vaddr = '0;
    logic         iflush = 1'b0;
    logic         resp_ready;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic [39:0]  resp_vaddr;
    logic         resp_xcpt;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [39:0]  mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [127:0] mem_rsp_data = '0;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    localparam logic [127:0] LA5 = {16{8'hA5}};
    localparam logic [127:0] L5A = {16{8'h5A}};
    localparam logic [127:0] LC3 = {16{8'hC3}};
    localparam logic [127:0] L3C = {16{8'h3C}};

    icache_fetch_responder dut (
        .clk(clk), .rsn(rsn), .req_valid(req_valid), .req_kill(req_kill), .req_vaddr(req_vaddr),
        .iflush(iflush), .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_vaddr(resp_vaddr), .resp_xcpt(resp_xcpt), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rsn && mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // zero-latency miss: accept, handshake, data beat, then check the response
    task automatic fetch_miss(input logic [39:0] addr, input logic [127:0] data);
        req_valid = 1'b1;
        req_vaddr = addr;
        step();
        req_valid = 1'b0;
        check("fm_mreq_valid", 128'(mem_req_valid), 128'(1));
        check("fm_mreq_addr", 128'(mem_req_addr), 128'({addr[39:4], 4'h0}));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        step();
        mem_rsp_valid = 1'b0;
        check("fm_resp_valid", 128'(resp_valid), 128'(1));
        check("fm_resp_data", resp_data, data);
        check("fm_resp_vaddr", 128'(resp_vaddr), 128'(addr));
    endtask

    initial begin
        #12;
        check("rst_ready", 128'(resp_ready), 128'(1));
        check("rst_valid", 128'(resp_valid), 128'(0));
        check("rst_xcpt", 128'(resp_xcpt), 128'(0));
        check("rst_mreq", 128'(mem_req_valid), 128'(0));
        check("rst_data", resp_data, 128'(0));
        check("rst_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));
        rsn = 1'b1;
        step();

        // miss with memory latency 2
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0010;
        step();
        req_valid = 1'b0;
        check("m1_mreq_valid", 128'(mem_req_valid), 128'(1));
        check("m1_mreq_addr", 128'(mem_req_addr), 128'(40'h0_8000_0010));
        check("m1_ready", 128'(resp_ready), 128'(0));
        check("m1_miss_cnt", 128'(miss_cnt), 128'(1));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("m1_mreq_drop", 128'(mem_req_valid), 128'(0));
        step();
        step();
        check("m1_no_early_resp", 128'(resp_valid), 128'(0));
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = LA5;
        step();
        mem_rsp_valid = 1'b0;
        check("m1_resp_valid", 128'(resp_valid), 128'(1));
        check("m1_resp_data", resp_data, LA5);
        check("m1_resp_vaddr", 128'(resp_vaddr), 128'(40'h0_8000_0010));
        check("m1_resp_xcpt", 128'(resp_xcpt), 128'(0));
        check("m1_ready_back", 128'(resp_ready), 128'(1));
        step();
        check("m1_single_pulse", 128'(resp_valid), 128'(0));
        check("m1_hs_once", 128'(hs_cnt), 128'(1));

        // back-to-back hits
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0018;
        step();
        check("h1_valid", 128'(resp_valid), 128'(1));
        check("h1_data", resp_data, LA5);
        check("h1_vaddr", 128'(resp_vaddr), 128'(40'h0_8000_0018));
        req_vaddr = 40'h0_8000_0014;
        step();
        req_valid = 1'b0;
        check("h2_valid", 128'(resp_valid), 128'(1));
        check("h2_data", resp_data, LA5);
        check("h2_vaddr", 128'(resp_vaddr), 128'(40'h0_8000_0014));
        check("h_hit_cnt", 128'(hit_cnt), 128'(2));
        check("h_no_mreq", 128'(mem_req_valid), 128'(0));
        check("h_hs", 128'(hs_cnt), 128'(1));

        // out-of-range below and at the top boundary
        req_valid = 1'b1;
        req_vaddr = 40'h0_7FFF_FFF0;
        step();
        check("x1_valid", 128'(resp_valid), 128'(1));
        check("x1_xcpt", 128'(resp_xcpt), 128'(1));
        check("x1_data", resp_data, 128'(0));
        check("x1_no_mreq", 128'(mem_req_valid), 128'(0));
        req_vaddr = 40'h0_9000_0000;
        step();
        req_valid = 1'b0;
        check("x2_xcpt", 128'({resp_valid, resp_xcpt}), 128'(3));
        check("x_cnts", 128'({hit_cnt, miss_cnt}), 128'({32'd2, 32'd1}));
        step();
        check("x_ready", 128'(resp_ready), 128'(1));

        // kill in MISS_WAIT, memory returns 4 cycles later
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0100;
        step();
        req_valid = 1'b0;
        check("k_mreq_addr", 128'(mem_req_addr), 128'(40'h0_8000_0100));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        req_kill = 1'b1;
        step();
        req_kill = 1'b0;
        step();
        step();
        check("k_drain_ready", 128'(resp_ready), 128'(0));
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = L5A;
        step();
        mem_rsp_valid = 1'b0;
        check("k_no_resp", 128'(resp_valid), 128'(0));
        check("k_ready_back", 128'(resp_ready), 128'(1));
        check("k_miss_cnt", 128'(miss_cnt), 128'(2));
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0108;
        step();
        req_valid = 1'b0;
        check("k_hit_valid", 128'(resp_valid), 128'(1));
        check("k_hit_data", resp_data, L5A);
        check("k_hit_cnt", 128'(hit_cnt), 128'(3));

        // iflush together with a lookup of the buffered line
        fetch_miss(40'h0_8000_0010, LA5);
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0010;
        iflush    = 1'b1;
        step();
        req_valid = 1'b0;
        iflush    = 1'b0;
        check("f_no_hit", 128'(resp_valid), 128'(0));
        check("f_mreq", 128'(mem_req_valid), 128'(1));
        check("f_miss_cnt", 128'(miss_cnt), 128'(4));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = LC3;
        step();
        mem_rsp_valid = 1'b0;
        check("f_refill_data", resp_data, LC3);

        // iflush on the data beat: response delivered, buffer left invalid
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0200;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = L3C;
        iflush        = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        iflush        = 1'b0;
        check("fw_resp", 128'(resp_valid), 128'(1));
        check("fw_data", resp_data, L3C);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("fw_refetch_miss", 128'({resp_valid, mem_req_valid}), 128'(1));
        check("fw_miss_cnt", 128'(miss_cnt), 128'(6));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;

        // reset during MISS_WAIT, then a stale data beat
        req_valid = 1'b1;
        req_vaddr = 40'h0_8000_0300;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rsn = 1'b0;
        #1;
        check("r_ready", 128'(resp_ready), 128'(1));
        check("r_mreq", 128'(mem_req_valid), 128'(0));
        check("r_mreq_addr", 128'(mem_req_addr), 128'(0));
        check("r_data", resp_data, 128'(0));
        check("r_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));
        rsn = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {16{8'hFF}};
        step();
        mem_rsp_valid = 1'b0;
        check("r_stale_ignored", 128'(resp_valid), 128'(0));
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("r_first_miss", 128'({resp_valid, mem_req_valid}), 128'(1));
        check("r_miss_cnt", 128'(miss_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Synthesizable instruction-cache responder. It accepts core fetch requests (the valid/kill/vaddr request side) and returns fetch responses (ready/valid/data/vaddr/xcpt).
- Used in the standalone core environment in place of the real icache, so that the core can be driven against a simple refill memory.
- Holds a single-line fetch buffer. Hits return in 1 cycle; misses issue a line refill on a memory port.
- Handles kill and iflush, and keeps hit/miss counters for coverage.

Parameters:
- ADDR_W, 40: width of the fetch virtual address, treated as physical.
- LINE_W, 128: fetch line width in bits. Must be a power of two, at least 32.
- MEM_BASE, 40'h0_8000_0000: lowest legal fetch address.
- MEM_SIZE, 40'h0_1000_0000: size in bytes of the legal fetch window.
- CNT_W, 32: width of the perf counters.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- rsn, in, 1: asynchronous active-low reset.
- req_valid, in, 1: core fetch request valid.
- req_kill, in, 1: core cancels an outstanding fetch.
- req_vaddr, in, ADDR_W: fetch address.
- iflush, in, 1: invalidate the fetch buffer.
- resp_ready, out, 1: responder can accept a request this cycle.
- resp_valid, out, 1: response valid. Asserted for a single cycle per response.
- resp_data, out, LINE_W: fetched line.
- resp_vaddr, out, ADDR_W: echo of the request address.
- resp_xcpt, out, 1: fetch access fault.
- mem_req_valid, out, 1: refill request.
- mem_req_ready, in, 1: memory accepts the refill request.
- mem_req_addr, out, ADDR_W: line-aligned refill address.
- mem_rsp_valid, in, 1: refill data valid.
- mem_rsp_data, in, LINE_W: refill line.
- hit_cnt, out, CNT_W: number of accepted buffer hits.
- miss_cnt, out, CNT_W: number of refills issued.

Behaviour:
- Definitions:
  - OFF = log2(LINE_W/8).
  - Line tag = req_vaddr[ADDR_W-1:OFF].
  - mem_req_addr = {tag, OFF'b0}.
- Reset (rsn low, asynchronous):
  - State goes to IDLE.
  - resp_ready=1. resp_valid, resp_xcpt and mem_req_valid are 0.
  - resp_data, resp_vaddr and mem_req_addr are 0.
  - Buffer valid bit and both counters are 0.
- Accept rule: a request is accepted when req_valid && resp_ready && !req_kill. resp_ready is 1 only in IDLE.
- IDLE, accepted request, address out of range (vaddr < MEM_BASE or vaddr >= MEM_BASE+MEM_SIZE):
  - Next cycle: resp_valid=1, resp_xcpt=1, resp_data=0.
  - No memory access, buffer unchanged, no counter change.
- IDLE, accepted request, buffer valid and tag matches:
  - Next cycle: resp_valid=1, resp_data=buffer, resp_xcpt=0.
  - hit_cnt+1. State stays IDLE, so back-to-back hits give throughput 1 per cycle.
- IDLE, accepted request, miss:
  - Latch vaddr and move to MISS_REQ.
  - miss_cnt+1. resp_ready=0 from the next cycle.
- MISS_REQ:
  - mem_req_valid=1 with a stable mem_req_addr.
  - On mem_req_ready, move to MISS_WAIT. mem_req_valid drops the following cycle.
- MISS_WAIT:
  - On mem_rsp_valid, write the buffer (tag, data, valid=1) and move to IDLE.
  - The next cycle has resp_valid=1 with that data. Minimum miss latency is 3 cycles from acceptance, given zero memory latency.
- resp_vaddr always echoes the address of the request being answered.
- Kill:
  - req_kill in MISS_REQ before the handshake: go to IDLE, no response, mem_req_valid drops the next cycle.
  - req_kill in MISS_REQ in the same cycle as mem_req_ready: go to DRAIN.
  - req_kill in MISS_WAIT: go to DRAIN.
  - DRAIN: resp_ready=0. On mem_rsp_valid, fill the buffer, do not respond, go to IDLE.
  - req_kill in IDLE only blocks acceptance. A hit/xcpt response already scheduled for the next cycle is still presented.
  - miss_cnt is not decremented on kill.
- iflush:
  - Clears the buffer valid bit at the clock edge.
  - A lookup in the same cycle as iflush is treated as a miss.
  - iflush during MISS_REQ, MISS_WAIT or DRAIN marks the refill as no-fill. In MISS_WAIT the response is still delivered, but the buffer stays invalid.
  - iflush together with mem_rsp_valid: flush wins, buffer stays invalid.
- mem_rsp_valid in IDLE or MISS_REQ is ignored, and must not corrupt the buffer.
- Counters saturate at all-ones. They are only cleared by reset.
- Reset mid-miss: all state is dropped. A stale mem_rsp_valid after reset is ignored.

Test Plan:
- Reset, then req_vaddr=0x8000_0010 with memory latency 2, returning line 0xA5..A5 → mem_req_addr=0x8000_0010 once. resp_valid 5 cycles after acceptance with data 0xA5..A5. miss_cnt=1.
- Same line re-fetched at 0x8000_0018, then 0x8000_0014 on consecutive cycles → two resp_valid on consecutive cycles with data 0xA5..A5. hit_cnt=2, no mem_req_valid.
- req_vaddr=0x7FFF_FFF0 → the next cycle has resp_valid=1, resp_xcpt=1, resp_data=0. No refill.
- Miss to 0x8000_0100, req_kill in MISS_WAIT, memory returns after 4 cycles → no resp_valid. resp_ready returns to 1 the cycle after mem_rsp_valid. A following fetch to 0x8000_0100 hits.
- Buffer holds 0x8000_0010, then iflush is asserted together with a fetch of 0x8000_0010 → the fetch is treated as a miss: refill issued, miss_cnt increments.
- Reset asserted during MISS_WAIT, then a stray mem_rsp_valid after reset → outputs are at their reset values. The first fetch after reset misses.
